mdio_arbiter: RTL and testbench

MDIO_ARBITER -- requirements
Module: mdio_arbiter

---
 rtl/mdio_arbiter_if.sv | 31 +++
 rtl/mdio_arbiter.sv | 129 ++++++++++++
 tb/tb_mdio_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_arbiter_if.sv
// Bus bundle between two MDIO requesters, the arbiter and the MDIO frame engine.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters and the frame engine.
interface mdio_arbiter_if;
  logic [1:0]  REQ;
  logic [1:0]  OP;
  logic [9:0]  ADDR0;
  logic [9:0]  ADDR1;
  logic [15:0] WDATA0;
  logic [15:0] WDATA1;
  logic [1:0]  GNT;
  logic [1:0]  DONE;
  logic [15:0] RDATA;
  logic        ERR;
  logic        MDIO_START;
  logic        MDIO_OP;
  logic [9:0]  MDIO_ADDR;
  logic [15:0] MDIO_WDATA;
  logic        MDIO_DONE;
  logic [15:0] MDIO_RDATA;

  modport slave (
    input  REQ, OP, ADDR0, ADDR1, WDATA0, WDATA1, MDIO_DONE, MDIO_RDATA,
    output GNT, DONE, RDATA, ERR, MDIO_START, MDIO_OP, MDIO_ADDR, MDIO_WDATA
  );

  modport master (
    output REQ, OP, ADDR0, ADDR1, WDATA0, WDATA1, MDIO_DONE, MDIO_RDATA,
    input  GNT, DONE, RDATA, ERR, MDIO_START, MDIO_OP, MDIO_ADDR, MDIO_WDATA
  );
endinterface

// File: rtl/mdio_arbiter.sv
// Two-requester arbiter in front of a single MDIO frame engine.
// Flow: IDLE -> ISSUE (start strobe) -> WAIT (frame engine busy) -> FINISH -> IDLE.
// Ties go to the requester not served last; all outputs are registered.
// Optional build macro MDIO_ARB_TIMEOUT_EN adds a 200-cycle WAIT timeout that
// completes the transaction with ERR=1 (and RDATA=16'hFFFF for reads).
module mdio_arbiter (
  input  logic           MDC,
  input  logic           reset,
  mdio_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t      state_q;
  logic        g_q;        // index of the granted requester
  logic        last_q;     // index of the requester served last
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic        start_q;
  logic        op_q;
  logic [9:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        win_d;      // winner of the current arbitration round

`ifdef MDIO_ARB_TIMEOUT_EN
  logic [7:0]  cnt_q;
  logic        tout_q;     // current transaction ended by timeout
  logic        err_q;
`endif

  // Winner select: a lone request wins outright, a tie goes to the one not served last
  always_comb begin
    win_d = 1'b0;
    if (bus.REQ == 2'b10)
      win_d = 1'b1;
    else if (bus.REQ == 2'b11)
      win_d = ~last_q;
  end

  // Arbitration FSM with registered outputs; MDIO_DONE is only looked at in WAIT
  always_ff @(posedge MDC) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      start_q <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
`ifdef MDIO_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tout_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q  <= 2'b00;
      start_q <= 1'b0;
`ifdef MDIO_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.REQ != 2'b00) begin
            g_q     <= win_d;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            op_q    <= bus.OP[win_d];
            addr_q  <= win_d ? bus.ADDR1 : bus.ADDR0;
            wdata_q <= win_d ? bus.WDATA1 : bus.WDATA0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b1;
          state_q <= WAIT;
`ifdef MDIO_ARB_TIMEOUT_EN
          cnt_q   <= 8'd0;
          tout_q  <= 1'b0;
`endif
        end
        WAIT: begin
          // A real completion beats a timeout landing in the same cycle
          if (bus.MDIO_DONE) begin
            if (op_q)
              rdata_q <= bus.MDIO_RDATA;
            state_q <= FINISH;
          end
`ifdef MDIO_ARB_TIMEOUT_EN
          else if (cnt_q == 8'd199) begin
            tout_q  <= 1'b1;
            if (op_q)
              rdata_q <= 16'hFFFF;
            state_q <= FINISH;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        FINISH: begin
          done_q  <= g_q ? 2'b10 : 2'b01;
          gnt_q   <= 2'b00;
          last_q  <= g_q;
          state_q <= IDLE;
`ifdef MDIO_ARB_TIMEOUT_EN
          err_q   <= tout_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.GNT        = gnt_q;
  assign bus.DONE       = done_q;
  assign bus.RDATA      = rdata_q;
  assign bus.MDIO_START = start_q;
  assign bus.MDIO_OP    = op_q;
  assign bus.MDIO_ADDR  = addr_q;
  assign bus.MDIO_WDATA = wdata_q;
`ifdef MDIO_ARB_TIMEOUT_EN
  assign bus.ERR        = err_q;
`else
  assign bus.ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter: stimulus pushes expected issue/completion
// records, a negedge monitor pops and compares them when the DUT strobes
// MDIO_START or DONE.
module tb_mdio_arbiter;

  logic MDC = 1'b0;
  logic reset;
  always #5 MDC = ~MDC;

  mdio_arbiter_if bus();

  mdio_arbiter dut (
    .MDC   (MDC),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  gnt;
    logic        op;
    logic [9:0]  addr;
    logic [15:0] wdata;
  } iss_t;

  typedef struct packed {
    logic [1:0]  done;
    logic [15:0] rdata;
    logic        err;
  } fin_t;

  iss_t iss_q[$];
  fin_t fin_q[$];
  iss_t ie;
  fin_t fe;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic prev_start = 1'b0;
  int   cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge MDC);
    #1;
  endtask

  task automatic wait_start(input string name);
    int k = 0;
    while (!bus.MDIO_START && k < 20) begin
      tick();
      k++;
    end
    if (!bus.MDIO_START) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: MDIO_START not seen within 20 cycles", name);
    end
  endtask

  task automatic wait_done(input string name, input int budget, output int c);
    c = 0;
    while (bus.DONE == 2'b00 && c < budget) begin
      tick();
      c++;
    end
    if (bus.DONE == 2'b00) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: DONE not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_mdio_done(input logic [15:0] rd);
    bus.MDIO_DONE  = 1'b1;
    bus.MDIO_RDATA = rd;
    tick();
    bus.MDIO_DONE  = 1'b0;
    bus.MDIO_RDATA = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Monitor: compare strobed issues and completions against the scoreboard
  always @(negedge MDC) begin
    if (mon_en) begin
      if (bus.MDIO_START) begin
        check("start_one_cycle", {31'd0, prev_start}, 32'd0);
        if (iss_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: got addr %h expected no issue", bus.MDIO_ADDR);
        end else begin
          ie = iss_q.pop_front();
          check("iss_gnt",   {30'd0, bus.GNT},        {30'd0, ie.gnt});
          check("iss_op",    {31'd0, bus.MDIO_OP},    {31'd0, ie.op});
          check("iss_addr",  {22'd0, bus.MDIO_ADDR},  {22'd0, ie.addr});
          check("iss_wdata", {16'd0, bus.MDIO_WDATA}, {16'd0, ie.wdata});
        end
      end
      prev_start = bus.MDIO_START;
      if (bus.DONE != 2'b00) begin
        if (fin_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got DONE %b expected none", bus.DONE);
        end else begin
          fe = fin_q.pop_front();
          check("fin_done",  {30'd0, bus.DONE},  {30'd0, fe.done});
          check("fin_rdata", {16'd0, bus.RDATA}, {16'd0, fe.rdata});
          check("fin_err",   {31'd0, bus.ERR},   {31'd0, fe.err});
          check("fin_gnt0",  {30'd0, bus.GNT},   32'd0);
        end
      end else if (bus.ERR) begin
        n_chk++;
        n_fail++;
        $display("FAIL err_without_done: got ERR 1 expected 0");
      end
      if (bus.GNT == 2'b11) begin
        n_chk++;
        n_fail++;
        $display("FAIL gnt_onehot: got GNT 11 expected one-hot or zero");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.REQ = 2'b00;  bus.OP = 2'b00;
    bus.ADDR0 = 10'd0; bus.ADDR1 = 10'd0;
    bus.WDATA0 = 16'd0; bus.WDATA1 = 16'd0;
    bus.MDIO_DONE = 1'b0; bus.MDIO_RDATA = 16'd0;
    do_reset();
    mon_en = 1'b1;

    // Reset state
    check("rst_gnt",   {30'd0, bus.GNT},        32'd0);
    check("rst_done",  {30'd0, bus.DONE},       32'd0);
    check("rst_err",   {31'd0, bus.ERR},        32'd0);
    check("rst_start", {31'd0, bus.MDIO_START}, 32'd0);
    check("rst_op",    {31'd0, bus.MDIO_OP},    32'd0);
    check("rst_addr",  {22'd0, bus.MDIO_ADDR},  32'd0);
    check("rst_wdata", {16'd0, bus.MDIO_WDATA}, 32'd0);
    check("rst_rdata", {16'd0, bus.RDATA},      32'd0);

    // Single write from requester 0; frame engine returns junk read data
    bus.OP = 2'b00; bus.ADDR0 = 10'h0A3; bus.WDATA0 = 16'h1234;
    iss_q.push_back('{gnt: 2'b01, op: 1'b0, addr: 10'h0A3, wdata: 16'h1234});
    fin_q.push_back('{done: 2'b01, rdata: 16'h0000, err: 1'b0});
    bus.REQ = 2'b01;
    tick();
    check("wr_gnt_next", {30'd0, bus.GNT}, 32'h1);
    wait_start("wr_start");
    tick(2);
    pulse_mdio_done(16'h5555);
    wait_done("wr_done", 20, cyc);
    bus.REQ = 2'b00;

    // Read from requester 1
    bus.OP = 2'b10; bus.ADDR1 = 10'h155; bus.WDATA1 = 16'hAAAA;
    iss_q.push_back('{gnt: 2'b10, op: 1'b1, addr: 10'h155, wdata: 16'hAAAA});
    fin_q.push_back('{done: 2'b10, rdata: 16'hBEEF, err: 1'b0});
    bus.REQ = 2'b10;
    wait_start("rd_start");
    tick();
    pulse_mdio_done(16'hBEEF);
    wait_done("rd_done", 20, cyc);
    bus.REQ = 2'b00;
    tick(3);
    check("rd_rdata_hold", {16'd0, bus.RDATA}, 32'hBEEF);

    // Tie after reset: alternating grants, one idle cycle between DONE and next GNT
    do_reset();
    bus.OP = 2'b00; bus.ADDR0 = 10'h011; bus.ADDR1 = 10'h022;
    bus.WDATA0 = 16'h1111; bus.WDATA1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        iss_q.push_back('{gnt: 2'b01, op: 1'b0, addr: 10'h011, wdata: 16'h1111});
        fin_q.push_back('{done: 2'b01, rdata: 16'h0000, err: 1'b0});
      end else begin
        iss_q.push_back('{gnt: 2'b10, op: 1'b0, addr: 10'h022, wdata: 16'h2222});
        fin_q.push_back('{done: 2'b10, rdata: 16'h0000, err: 1'b0});
      end
    end
    bus.REQ = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_start("tie_start");
      pulse_mdio_done(16'h0000);
      wait_done("tie_done", 20, cyc);
      if (i == 3) bus.REQ = 2'b00;
      check("tie_gnt_in_done", {30'd0, bus.GNT}, 32'd0);
      if (i < 3) begin
        tick();
        check("tie_gap_gnt", {30'd0, bus.GNT}, (i % 2 == 0) ? 32'h2 : 32'h1);
      end
    end

    // Robustness: drop REQ and scramble inputs mid-transaction
    tick(2);
    bus.OP = 2'b00; bus.ADDR0 = 10'h3FF; bus.WDATA0 = 16'hCAFE;
    iss_q.push_back('{gnt: 2'b01, op: 1'b0, addr: 10'h3FF, wdata: 16'hCAFE});
    fin_q.push_back('{done: 2'b01, rdata: 16'h0000, err: 1'b0});
    bus.REQ = 2'b01;
    wait_start("rob_start");
    bus.REQ = 2'b00; bus.OP = 2'b01; bus.ADDR0 = 10'h000; bus.WDATA0 = 16'h0000;
    tick(3);
    check("rob_addr_stable",  {22'd0, bus.MDIO_ADDR},  32'h3FF);
    check("rob_wdata_stable", {16'd0, bus.MDIO_WDATA}, 32'hCAFE);
    check("rob_gnt_held",     {30'd0, bus.GNT},        32'h1);
    pulse_mdio_done(16'h9999);
    wait_done("rob_done", 20, cyc);
    bus.OP = 2'b00;

    // MDIO_DONE while idle must change nothing
    tick(2);
    pulse_mdio_done(16'h1234);
    tick(3);
    check("idle_mdone_rdata", {16'd0, bus.RDATA}, 32'd0);
    check("idle_mdone_gnt",   {30'd0, bus.GNT},   32'd0);
    check("idle_mdone_done",  {30'd0, bus.DONE},  32'd0);

    // Reset during WAIT abandons the transaction
    bus.OP = 2'b10; bus.ADDR1 = 10'h044; bus.WDATA1 = 16'h0000;
    iss_q.push_back('{gnt: 2'b10, op: 1'b1, addr: 10'h044, wdata: 16'h0000});
    bus.REQ = 2'b10;
    wait_start("rstw_start");
    tick(2);
    reset = 1'b1;
    bus.REQ = 2'b00;
    tick();
    reset = 1'b0;
    check("rstw_gnt", {30'd0, bus.GNT}, 32'd0);
    pulse_mdio_done(16'hABCD);
    tick(3);
    check("rstw_no_done", {30'd0, bus.DONE},  32'd0);
    check("rstw_rdata",   {16'd0, bus.RDATA}, 32'd0);

    // Read with a silent frame engine
    bus.OP = 2'b10; bus.ADDR1 = 10'h0C8; bus.WDATA1 = 16'h0000;
    iss_q.push_back('{gnt: 2'b10, op: 1'b1, addr: 10'h0C8, wdata: 16'h0000});
    bus.REQ = 2'b10;
    wait_start("to_start");
`ifdef MDIO_ARB_TIMEOUT_EN
    fin_q.push_back('{done: 2'b10, rdata: 16'hFFFF, err: 1'b1});
    wait_done("to_done", 250, cyc);
    bus.REQ = 2'b00;
    check("to_latency_window", {31'd0, (cyc >= 200 && cyc <= 202)}, 32'd1);
`else
    tick(300);
    check("nto_gnt_held", {30'd0, bus.GNT},  32'h2);
    check("nto_no_done",  {30'd0, bus.DONE}, 32'd0);
    check("nto_err",      {31'd0, bus.ERR},  32'd0);
    fin_q.push_back('{done: 2'b10, rdata: 16'h7777, err: 1'b0});
    pulse_mdio_done(16'h7777);
    wait_done("nto_done", 20, cyc);
    bus.REQ = 2'b00;
`endif

    tick(3);
    check("iss_q_drained", iss_q.size(), 32'd0);
    check("fin_q_drained", fin_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
